// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// -----------------------------------------------------------------------------
// Shares the single write port of an async FIFO among NUM_REQ requesters. All
// of this logic runs in the FIFO write clock domain.
//
// Arbitration is round-robin. A source that wins the grant keeps it for at most
// MAX_BURST words. Every change of ownership goes through IDLE, so there is one
// bubble cycle between bursts. While the FIFO reports full, the current owner
// stalls and keeps its grant.
//
// Ports
//   wr_clk    : write-domain clock (the only clock)
//   rst       : asynchronous, active-high reset
//   req       : req[i]=1 means source i has a word on its req_data slice
//   req_data  : source i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      : FIFO full flag (wr_clk domain)
//   gnt       : one-hot; gnt[i]=1 means source i's word is written this cycle
//   wr_en     : FIFO write enable
//   din       : FIFO write data (zero when no write is issued)
//   owner     : index of the current owner, or of the last owner
//   busy      : high while a source owns the write port (GRANT state)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         din,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;

    logic [OW-1:0] next_owner;
    logic          rr_found;
    logic [OW:0]   rr_sum;
    logic [OW-1:0] rr_idx;
    logic          xfer;
    logic          burst_last;

    // Round-robin search for the next owner. The search starts at the slot
    // after the previous owner and wraps modulo NUM_REQ, so the previous owner
    // is checked last. The sum carries one extra bit, which keeps the wrap
    // correct when NUM_REQ is not a power of two. Reset leaves owner at
    // NUM_REQ-1, so source 0 has first priority after reset.
    always_comb begin
        next_owner = owner;
        rr_found   = 1'b0;
        rr_sum     = '0;
        rr_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, owner} + (OW+1)'(k);
            if (rr_sum >= (OW+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (OW+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[OW-1:0];
            if (!rr_found && req[rr_idx]) begin
                next_owner = rr_idx;
                rr_found   = 1'b1;
            end
        end
    end

    // A word moves only when the owner still requests and the FIFO has room.
    // burst_last marks the final word the owner may write in this burst.
    always_comb begin
        xfer       = (state == GRANT) && req[owner] && !full;
        burst_last = (burst_cnt == BW'(MAX_BURST - 1));
    end

    // The write port is driven combinationally from the registered owner, so
    // the owner's word reaches the FIFO in the same cycle it is granted. The
    // state register has an asynchronous reset, so these outputs fall to zero
    // as soon as rst rises.
    always_comb begin
        gnt   = '0;
        din   = '0;
        wr_en = xfer;
        busy  = (state == GRANT);
        if (xfer) begin
            gnt = NUM_REQ'(1) << owner;
            din = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Control FSM. IDLE picks the next owner and clears the burst count, and
    // it never writes. GRANT releases ownership when the owner drops req or
    // when it writes its last allowed word. While the FIFO is full, GRANT holds
    // both the owner and burst_cnt. On leaving GRANT the owner index stays in
    // place, because the next round-robin search starts from it.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= next_owner;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[owner]) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        if (burst_last) begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Invariants of the write port. At most one source is granted. A write
    // never happens while the FIFO is full. The owner index always names a
    // real source.
    a_gnt_onehot : assert property (@(posedge wr_clk) disable iff (rst)
        $onehot0(gnt));
    a_wr_en_gnt : assert property (@(posedge wr_clk) disable iff (rst)
        wr_en == |gnt);
    a_no_write_full : assert property (@(posedge wr_clk) disable iff (rst)
        !(wr_en && full));
    a_owner_range : assert property (@(posedge wr_clk) disable iff (rst)
        int'(owner) < NUM_REQ);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// -----------------------------------------------------------------------------
// Self-checking bench for fifo_wr_arbiter with NUM_REQ=4, DATA_WIDTH=8 and
// MAX_BURST=4. Source i always presents the word 8'hA0+i.
//
// Each scenario task does three things. First, it pushes the words the FIFO
// should receive into a scoreboard queue. Second, it drives req/full once per
// cycle. Third, it checks gnt/busy/owner inline. A negedge monitor pops the
// scoreboard on every wr_en and compares gnt/din against the popped entry. The
// monitor also checks the write-port invariants on every cycle.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          wr_clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         din;
    logic [1:0]                    owner;
    logic                          busy;

    typedef struct packed {
        logic [NUM_REQ-1:0]    gnt;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wr_clk  (wr_clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .full    (full),
        .gnt     (gnt),
        .wr_en   (wr_en),
        .din     (din),
        .owner   (owner),
        .busy    (busy)
    );

    // 10-unit write clock
    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Expected FIFO word for one write by source src
    function automatic exp_t word_of(input int src);
        exp_t e;
        e.gnt  = NUM_REQ'(1 << src);
        e.data = DATA_WIDTH'(8'hA0 + src);
        return e;
    endfunction

    // Scoreboard monitor: every FIFO write must match the oldest expected word,
    // and the write-port invariants must hold on every cycle
    always @(negedge wr_clk) begin
        n_cmp++;
        if (wr_en !== (|gnt)) begin
            n_fail++;
            $display("[TB] FAIL mon_wr_en_vs_gnt: wr_en=%b gnt=%b required wr_en=%b", wr_en, gnt, |gnt);
        end
        n_cmp++;
        if ((wr_en & full) !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mon_write_while_full: wr_en=%b full=%b required no write", wr_en, full);
        end
        if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL mon_unexpected_write: gnt=%b din=%h required no write", gnt, din);
            end else begin
                mon_exp = sb.pop_front();
                if ({gnt, din} !== mon_exp) begin
                    n_fail++;
                    $display("[TB] FAIL mon_word: gnt=%b din=%h required gnt=%b din=%h",
                             gnt, din, mon_exp.gnt, mon_exp.data);
                end
            end
        end
    end

    // Drive the per-cycle request and back-pressure inputs
    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic f);
        req  = r;
        full = f;
    endtask

    // Move to the next drive point, 1 unit after the rising edge
    task automatic next_cycle();
        @(posedge wr_clk);
        #1;
    endtask

    // Reset with requests r applied. Returns in cycle 0, just after release.
    task automatic do_reset(input logic [NUM_REQ-1:0] r);
        rst = 1'b1;
        applyStimulus(r, 1'b0);
        repeat (2) @(posedge wr_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        @(posedge wr_clk);
        @(negedge wr_clk);
        n_cmp++;
        if ({gnt, wr_en, busy} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: gnt=%b wr_en=%b busy=%b required all 0", gnt, wr_en, busy);
        end
        n_cmp++;
        if (owner !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL reset_owner: owner=%0d required 3", owner);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge wr_clk);
        n_cmp++;
        if ({gnt, busy} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_bubble: gnt=%b busy=%b required 0", gnt, busy);
        end
        sb.push_back(word_of(0));
        next_cycle();
        @(negedge wr_clk);
        n_cmp++;
        if ({gnt, busy, owner} !== {4'b0001, 1'b1, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_first_grant: gnt=%b busy=%b owner=%0d required 0001 1 0", gnt, busy, owner);
        end
        next_cycle();
        applyStimulus(4'b0000, 1'b0);
        @(negedge wr_clk);
        next_cycle();
        @(negedge wr_clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: busy=%b required 0", busy);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_sb_drain: %0d words left required 0", sb.size());
        end
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] exp_gnt;
        $display("[TB] test_fairness");
        do_reset(4'b1111);
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < MAX_BURST; w++) begin
                sb.push_back(word_of(b % NUM_REQ));
            end
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge wr_clk);
            exp_gnt = (k % 5 == 0) ? 4'b0000 : NUM_REQ'(1 << ((k / 5) % NUM_REQ));
            n_cmp++;
            if (gnt !== exp_gnt) begin
                n_fail++;
                $display("[TB] FAIL fair_gnt k=%0d: gnt=%b required %b", k, gnt, exp_gnt);
            end
            n_cmp++;
            if (busy !== (k % 5 != 0)) begin
                n_fail++;
                $display("[TB] FAIL fair_busy k=%0d: busy=%b required %b", k, busy, (k % 5 != 0));
            end
            next_cycle();
        end
        applyStimulus(4'b0000, 1'b0);
        @(negedge wr_clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL fair_sb_drain: %0d words left required 0", sb.size());
        end
    endtask

    task automatic test_back_pressure();
        logic [NUM_REQ-1:0] exp_gnt;
        logic               exp_busy;
        $display("[TB] test_back_pressure");
        do_reset(4'b0100);
        for (int w = 0; w < MAX_BURST; w++) sb.push_back(word_of(2));
        for (int k = 0; k <= 10; k++) begin
            applyStimulus(4'b0100, (k >= 3 && k <= 7));
            @(negedge wr_clk);
            exp_gnt  = (k == 1 || k == 2 || k == 8 || k == 9) ? 4'b0100 : 4'b0000;
            exp_busy = (k >= 1 && k <= 9);
            n_cmp++;
            if ({gnt, wr_en} !== {exp_gnt, |exp_gnt}) begin
                n_fail++;
                $display("[TB] FAIL bp_gnt k=%0d: gnt=%b wr_en=%b required %b %b", k, gnt, wr_en, exp_gnt, |exp_gnt);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL bp_busy k=%0d: busy=%b required %b", k, busy, exp_busy);
            end
            if (k >= 1) begin
                n_cmp++;
                if (owner !== 2'd2) begin
                    n_fail++;
                    $display("[TB] FAIL bp_owner k=%0d: owner=%0d required 2", k, owner);
                end
            end
            next_cycle();
        end
        applyStimulus(4'b0000, 1'b0);
        @(negedge wr_clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_sb_drain: %0d words left required 0", sb.size());
        end
    endtask

    task automatic test_early_drop();
        logic [NUM_REQ-1:0] req_tab  [11];
        logic [NUM_REQ-1:0] gnt_tab  [11];
        logic               busy_tab [11];
        req_tab  = '{4'b0010, 4'b0010, 4'b1000, 4'b1010, 4'b1010, 4'b1010,
                     4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
        gnt_tab  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000,
                     4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
        busy_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        $display("[TB] test_early_drop");
        do_reset(4'b0010);
        sb.push_back(word_of(1));
        for (int w = 0; w < MAX_BURST; w++) sb.push_back(word_of(3));
        sb.push_back(word_of(1));
        for (int k = 0; k <= 10; k++) begin
            applyStimulus(req_tab[k], 1'b0);
            @(negedge wr_clk);
            n_cmp++;
            if (gnt !== gnt_tab[k]) begin
                n_fail++;
                $display("[TB] FAIL drop_gnt k=%0d: gnt=%b required %b", k, gnt, gnt_tab[k]);
            end
            n_cmp++;
            if (busy !== busy_tab[k]) begin
                n_fail++;
                $display("[TB] FAIL drop_busy k=%0d: busy=%b required %b", k, busy, busy_tab[k]);
            end
            if (k == 3) begin
                n_cmp++;
                if (owner !== 2'd1) begin
                    n_fail++;
                    $display("[TB] FAIL drop_rr_pointer: owner=%0d required 1", owner);
                end
            end
            next_cycle();
        end
        @(negedge wr_clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drop_sb_drain: %0d words left required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        $display("[TB] test_reset_mid_burst");
        do_reset(4'b0100);
        sb.push_back(word_of(2));
        sb.push_back(word_of(2));
        for (int k = 0; k < 3; k++) begin
            @(negedge wr_clk);
            next_cycle();
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, wr_en, busy, din} !== 14'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_outputs: gnt=%b wr_en=%b busy=%b din=%h required all 0", gnt, wr_en, busy, din);
        end
        n_cmp++;
        if (owner !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL midrst_owner: owner=%0d required 3", owner);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL midrst_pre_words: %0d words left required 0", sb.size());
        end
        next_cycle();
        rst = 1'b0;
        applyStimulus(4'b0101, 1'b0);
        @(negedge wr_clk);
        n_cmp++;
        if ({gnt, busy} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_bubble: gnt=%b busy=%b required 0", gnt, busy);
        end
        sb.push_back(word_of(0));
        next_cycle();
        @(negedge wr_clk);
        n_cmp++;
        if ({gnt, owner} !== {4'b0001, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL midrst_first_grant: gnt=%b owner=%0d required 0001 0", gnt, owner);
        end
        next_cycle();
        applyStimulus(4'b0000, 1'b0);
        @(negedge wr_clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL midrst_sb_drain: %0d words left required 0", sb.size());
        end
    endtask

    // Runs the scenarios in sequence and prints the summary
    initial begin
        rst      = 1'b1;
        req      = '0;
        full     = 1'b0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_fairness();
        test_back_pressure();
        test_early_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
